imem_loader: RTL and testbench

Boot-time program loader and reset sequencer for the 64-word instruction memory of the single-cycle ARM core. It accepts a length-prefixed word stream on a valid/ready port, writes each word into consecutive instruction-memory locations from address 0, and optionally verifies an XOR checksum. It holds the processor in reset until the image is complete and valid, and supports re-loading on request.

---
 rtl/imem_loader.sv | 166 ++++++++++++++++
 tb/tb_imem_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: length-prefixed word stream into instruction memory, holds core in reset until done.
// Optional trailing XOR checksum word enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    input  logic          reload,
    output logic          we,
    output logic [AW-1:0] wa,
    output logic [31:0]   wd,
    output logic          cpu_reset,
    output logic          done,
    output logic          error,
    output logic [AW:0]   loaded_count
);

    typedef enum logic [2:0] {
        S_COUNT,
        S_LOAD,
        S_RUN,
        S_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   n_q, n_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [31:0]   acc_q, acc_d;
    logic          in_ready_q, in_ready_d;
    logic          we_q, we_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [31:0]   wd_q, wd_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          accept;

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        we_d        = 1'b0;
        wa_d        = wa_q;
        wd_d        = wd_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;
        case (state_q)
            S_COUNT: begin
                if (accept) begin
                    if (in_data == 32'd0 || in_data > 32'(DEPTH)) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else begin
                        n_d     = in_data[AW:0];
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    we_d  = 1'b1;
                    wa_d  = cnt_q[AW-1:0];
                    wd_d  = in_data;
                    cnt_d = cnt_q + 1'b1;
                    acc_d = acc_q ^ in_data;
                    if ((cnt_q + 1'b1) == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_RUN;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                // The checksum word only decides the outcome; it is never written.
                if (accept) begin
                    if (in_data == acc_q) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            S_RUN: begin
                if (reload) begin
                    state_d     = S_COUNT;
                    done_d      = 1'b0;
                    cnt_d       = '0;
                    cpu_reset_d = 1'b1;
                end else begin
                    // Released one edge after done so the last write has landed.
                    cpu_reset_d = 1'b0;
                end
            end
            S_ERROR: begin
                if (reload) begin
                    state_d     = S_COUNT;
                    error_d     = 1'b0;
                    cnt_d       = '0;
                    cpu_reset_d = 1'b1;
                end
            end
            default: begin
                state_d = S_COUNT;
            end
        endcase
        in_ready_d = (state_d != S_RUN) && (state_d != S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_COUNT;
            n_q         <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            we_q        <= 1'b0;
            wa_q        <= '0;
            wd_q        <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            we_q        <= we_d;
            wa_q        <= wa_d;
            wd_q        <= wd_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign we           = we_q;
    assign wa           = wa_q;
    assign wd           = wd_q;
    assign cpu_reset    = cpu_reset_q;
    assign done         = done_q;
    assign error        = error_q;
    assign loaded_count = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - table-driven image loads with a write scoreboard, plus reload/reset corner sequences.
module tb_imem_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          reload;
    logic          we;
    logic [AW-1:0] wa;
    logic [31:0]   wd;
    logic          cpu_reset;
    logic          done;
    logic          error;
    logic [AW:0]   loaded_count;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .reload(reload), .we(we), .wa(wa), .wd(wd),
        .cpu_reset(cpu_reset), .done(done), .error(error), .loaded_count(loaded_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       n;
        int                nw;
        logic [3:0][31:0]  w;
        logic [31:0]       cs;
        bit                calc_cs;
        bit                gap;
        bit                exp_done;
        bit                exp_err;
        int                exp_lc;
    } vec_t;

    vec_t vecs[8];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cyc = -1;
    int rst_fall_cyc = -1;
    logic done_prev = 1'b0;
    logic cpu_prev = 1'b1;
    logic [AW+31:0] sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_we: got wa=%0d wd=%h expected no write", wa, wd);
            end else begin
                chk("write", 64'({wa, wd}), 64'(sb.pop_front()));
            end
        end
        if (done && !done_prev) done_cyc = cyc;
        if (!cpu_reset && cpu_prev) rst_fall_cyc = cyc;
        done_prev = done;
        cpu_prev  = cpu_reset;
    end

    task automatic drive_word(input logic [31:0] d, input bit is_prog, input int idx, output int acc_cyc);
        int guard;
        guard = 0;
        acc_cyc = -1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 for word %h", d);
            in_valid = 1'b0;
            return;
        end
        if (is_prog) sb.push_back({AW'(idx), d});
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload_in_ready", in_ready, 1);
        chk("reload_done", done, 0);
        chk("reload_error", error, 0);
        chk("reload_lc", loaded_count, 0);
        chk("reload_cpu_reset", cpu_reset, 1);
    endtask

    task automatic run_row(input vec_t v, input int row);
        logic [31:0] acc;
        logic [31:0] d;
        int start, t, gaps;
        bit legal;
        acc = '0;
        gaps = 0;
        done_cyc = -1;
        rst_fall_cyc = -1;
        legal = (v.n != 0) && (v.n <= DEPTH);
        drive_word(v.n, 1'b0, 0, start);
        if (legal) begin
            for (int i = 0; i < v.nw; i++) begin
                d = (i < 4) ? v.w[i] : 32'hA500_0000 + 32'(i);
                acc ^= d;
                if (v.gap) begin
                    @(negedge clk);
                    gaps++;
                end
                drive_word(d, 1'b1, i, t);
            end
            if (CSUM != 0) drive_word(v.calc_cs ? acc : v.cs, 1'b0, 0, t);
        end
        repeat (3) @(negedge clk);
        chk($sformatf("row%0d_done", row), done, v.exp_done);
        chk($sformatf("row%0d_error", row), error, v.exp_err);
        chk($sformatf("row%0d_lc", row), loaded_count, v.exp_lc);
        chk($sformatf("row%0d_cpu_reset", row), cpu_reset, !v.exp_done);
        chk($sformatf("row%0d_in_ready", row), in_ready, 0);
        if (v.exp_done) begin
            chk($sformatf("row%0d_done_latency", row), 64'(done_cyc - start), 64'(v.n + CSUM + gaps));
            chk($sformatf("row%0d_release_delay", row), 64'(rst_fall_cyc - done_cyc), 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        vec_t v;
        vecs[0] = '{32'd3, 3, {32'h0, 32'hE1A03211, 32'hE3A02003, 32'hE3A01002}, 32'hE1A00210, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        vecs[1] = '{32'd3, 3, {32'h0, 32'hE1A03211, 32'hE3A02003, 32'hE3A01002}, 32'h0, 1'b0, 1'b0, bit'(CSUM == 0), bit'(CSUM != 0), 3};
        vecs[2] = '{32'd0, 0, 128'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{32'd65, 0, 128'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[4] = '{32'd2, 2, {64'h0, 32'h22222222, 32'h11111111}, 32'h33333333, 1'b0, 1'b1, 1'b1, 1'b0, 2};
        vecs[5] = '{32'd64, 64, {32'h4, 32'h3, 32'h2, 32'h1}, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 64};
        vecs[6] = '{32'h8000_0001, 0, 128'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[7] = '{32'd1, 1, {96'h0, 32'hDEADBEEF}, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1};

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        reload   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_we", we, 0);
        chk("rst_wa", wa, 0);
        chk("rst_wd", wd, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_lc", loaded_count, 0);
        reset_n = 1'b1;

        for (int r = 0; r < 8; r++) begin
            if (r != 0) do_reload();
            run_row(vecs[r], r);
        end

        // Reload from RUN in the same cycle as a valid word: the word must be dropped.
        @(negedge clk);
        reload   = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'd1;
        @(posedge clk);
        #1;
        chk("same_edge_done", done, 0);
        chk("same_edge_cpu_reset", cpu_reset, 1);
        chk("same_edge_in_ready", in_ready, 1);
        reload   = 1'b0;
        in_valid = 1'b0;
        v = '{32'd1, 1, {96'h0, 32'h12345678}, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        run_row(v, 8);

        // Reset mid-load after 2 of 5 words.
        do_reload();
        drive_word(32'd5, 1'b0, 0, t);
        drive_word(32'hCAFE0000, 1'b1, 0, t);
        drive_word(32'hCAFE0001, 1'b1, 1, t);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("midrst_lc", loaded_count, 0);
        chk("midrst_cpu_reset", cpu_reset, 1);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_done", done, 0);
        v = '{32'd1, 1, {96'h0, 32'h0BADF00D}, 32'h0BADF00D, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        run_row(v, 9);

        // Reload during LOAD is ignored.
        do_reload();
        drive_word(32'd2, 1'b0, 0, t);
        drive_word(32'h00000AAA, 1'b1, 0, t);
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        drive_word(32'h00000555, 1'b1, 1, t);
        if (CSUM != 0) drive_word(32'h00000FFF, 1'b0, 0, t);
        repeat (3) @(negedge clk);
        chk("ld_reload_done", done, 1);
        chk("ld_reload_lc", loaded_count, 2);
        chk("ld_reload_cpu_reset", cpu_reset, 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
